// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: FSM states, ASCII codes,
// time-field limits and small byte-classification helpers.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   localparam logic [7:0] CH_R     = 8'h52;
   localparam logic [7:0] CH_C     = 8'h43;
   localparam logic [7:0] CH_M     = 8'h4D;
   localparam logic [7:0] CH_T     = 8'h54;
   localparam logic [7:0] CH_ESC   = 8'h1B;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;

   localparam logic [6:0] HOUR_MAX = 7'd23;
   localparam logic [6:0] MIN_MAX  = 7'd59;
   localparam logic [6:0] SEC_MAX  = 7'd59;

   // Folds 'a'..'z' onto 'A'..'Z' so command matching is case-insensitive.
   function automatic logic [7:0] to_upper(input logic [7:0] b);
      if (b >= 8'h61 && b <= 8'h7A) begin
         return b - 8'h20;
      end
      return b;
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CH_0) && (b <= CH_9);
   endfunction

endpackage

// File: rtl/uart_cmd_decoder_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYCLES-th quiet cycle elapses.
module cmd_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int CNT_W          = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A clear in the same cycle always suppresses expiry, so a byte wins a tie.
   assign o_expired = i_enable & ~i_clear & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear || o_expired) begin
         cnt_d = '0;
      end else if (i_enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes UART bytes into one-cycle control pulses and parses the
// "T HHMMSS" set-time command into validated binary time fields.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int CNT_W          = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_done,
   output logic       o_run_stop,
   output logic       o_clear,
   output logic       o_mode,
   output logic       o_set_valid,
   output logic [4:0] o_set_hour,
   output logic [5:0] o_set_min,
   output logic [5:0] o_set_sec,
   output logic       o_cmd_err,
   output logic       o_busy
);

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0][3:0] digits_q, digits_d;
   logic            done_q;
   logic            run_q, run_d;
   logic            clr_q, clr_d;
   logic            mode_q, mode_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic [4:0]      hour_q, hour_d;
   logic [5:0]      min_q, min_d;
   logic [5:0]      sec_q, sec_d;

   logic            ev;
   logic            expired;
   logic [7:0]      ch;
   logic [6:0]      hh, mm, ss;

   // One event per byte no matter how long the receiver holds done high.
   assign ev = i_rx_done & ~done_q;
   assign ch = to_upper(i_rx_data);

   assign hh = 7'(digits_q[0]) * 7'd10 + 7'(digits_q[1]);
   assign mm = 7'(digits_q[2]) * 7'd10 + 7'(digits_q[3]);
   assign ss = 7'(digits_q[4]) * 7'd10 + 7'(digits_q[5]);

   cmd_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (ev | (state_q != ST_COLLECT)),
      .i_enable  (state_q == ST_COLLECT),
      .o_expired (expired)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      digits_d = digits_q;
      run_d    = 1'b0;
      clr_d    = 1'b0;
      mode_d   = 1'b0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      hour_d   = hour_q;
      min_d    = min_q;
      sec_d    = sec_q;

      case (state_q)
         ST_IDLE: begin
            if (ev) begin
               case (ch)
                  CH_R: run_d  = 1'b1;
                  CH_C: clr_d  = 1'b1;
                  CH_M: mode_d = 1'b1;
                  CH_T: begin
                     state_d = ST_COLLECT;
                     idx_d   = 3'd0;
                  end
                  CH_CR, CH_LF, CH_SPACE: ;
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_COLLECT: begin
            if (ev) begin
               if (is_digit(i_rx_data)) begin
                  digits_d[idx_q] = i_rx_data[3:0];
                  if (idx_q == 3'd5) begin
                     state_d = ST_CHECK;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  err_d   = (i_rx_data != CH_ESC);
                  state_d = ST_IDLE;
               end
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            // Any byte event landing here is intentionally dropped.
            if (hh <= HOUR_MAX && mm <= MIN_MAX && ss <= SEC_MAX) begin
               valid_d = 1'b1;
               hour_d  = hh[4:0];
               min_d   = mm[5:0];
               sec_d   = ss[5:0];
            end else begin
               err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         digits_q <= '0;
         done_q   <= 1'b0;
         run_q    <= 1'b0;
         clr_q    <= 1'b0;
         mode_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         digits_q <= digits_d;
         done_q   <= i_rx_done;
         run_q    <= run_d;
         clr_q    <= clr_d;
         mode_q   <= mode_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
      end
   end

   assign o_run_stop  = run_q;
   assign o_clear     = clr_q;
   assign o_mode      = mode_q;
   assign o_set_valid = valid_q;
   assign o_set_hour  = hour_q;
   assign o_set_min   = min_q;
   assign o_set_sec   = sec_q;
   assign o_cmd_err   = err_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench: directed scenarios plus randomized byte traffic,
// compared every cycle against a queue-based behavioural model.
module tb_uart_cmd_decoder;

   localparam int TMO = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       o_run_stop, o_clear, o_mode, o_set_valid, o_cmd_err, o_busy;
   logic [4:0] o_set_hour;
   logic [5:0] o_set_min, o_set_sec;

   int checks = 0;
   int errors = 0;
   int n_run = 0, n_clr = 0, n_mode = 0, n_valid = 0, n_err = 0;

   uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rx_data   (i_rx_data),
      .i_rx_done   (i_rx_done),
      .o_run_stop  (o_run_stop),
      .o_clear     (o_clear),
      .o_mode      (o_mode),
      .o_set_valid (o_set_valid),
      .o_set_hour  (o_set_hour),
      .o_set_min   (o_set_min),
      .o_set_sec   (o_set_sec),
      .o_cmd_err   (o_cmd_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: tracks mode, collected digits and quiet time.
   int   m_mode = 0;   // 0 idle, 1 collecting, 2 validating
   bit   m_prev = 0;
   int   m_dig[$];
   int   m_quiet = 0;
   bit   e_run = 0, e_clr = 0, e_mode = 0, e_valid = 0, e_err = 0, e_busy = 0;
   int   e_hour = 0, e_min = 0, e_sec = 0;

   always @(posedge clk) begin
      bit        ev;
      logic [7:0] b;
      int        hh, mm, ss;
      if (reset) begin
         m_mode = 0; m_prev = 0; m_dig.delete(); m_quiet = 0;
         e_run = 0; e_clr = 0; e_mode = 0; e_valid = 0; e_err = 0; e_busy = 0;
         e_hour = 0; e_min = 0; e_sec = 0;
      end else begin
         ev = i_rx_done && !m_prev;
         m_prev = i_rx_done;
         b = i_rx_data;
         e_run = 0; e_clr = 0; e_mode = 0; e_valid = 0; e_err = 0;
         if (m_mode == 2) begin
            hh = m_dig[0] * 10 + m_dig[1];
            mm = m_dig[2] * 10 + m_dig[3];
            ss = m_dig[4] * 10 + m_dig[5];
            if (hh < 24 && mm < 60 && ss < 60) begin
               e_valid = 1; e_hour = hh; e_min = mm; e_sec = ss;
            end else begin
               e_err = 1;
            end
            m_mode = 0;
         end else if (m_mode == 1) begin
            if (ev) begin
               m_quiet = 0;
               if (b >= 8'h30 && b <= 8'h39) begin
                  m_dig.push_back(int'(b) - 48);
                  if (m_dig.size() == 6) m_mode = 2;
               end else begin
                  e_err = (b != 8'h1B);
                  m_mode = 0;
               end
            end else begin
               m_quiet++;
               if (m_quiet == TMO) begin
                  e_err = 1;
                  m_mode = 0;
               end
            end
         end else if (ev) begin
            case (b)
               8'h52, 8'h72: e_run = 1;
               8'h43, 8'h63: e_clr = 1;
               8'h4D, 8'h6D: e_mode = 1;
               8'h54, 8'h74: begin m_mode = 1; m_dig.delete(); m_quiet = 0; end
               8'h0D, 8'h0A, 8'h20: ;
               default: e_err = 1;
            endcase
         end
         e_busy = (m_mode != 0);
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      bit r;
      r = reset;
      check("run_stop", o_run_stop, r ? 0 : e_run);
      check("clear",    o_clear,    r ? 0 : e_clr);
      check("mode",     o_mode,     r ? 0 : e_mode);
      check("set_valid", o_set_valid, r ? 0 : e_valid);
      check("cmd_err",  o_cmd_err,  r ? 0 : e_err);
      check("busy",     o_busy,     r ? 0 : e_busy);
      check("set_hour", o_set_hour, r ? 0 : e_hour);
      check("set_min",  o_set_min,  r ? 0 : e_min);
      check("set_sec",  o_set_sec,  r ? 0 : e_sec);
      if (o_run_stop)  n_run++;
      if (o_clear)     n_clr++;
      if (o_mode)      n_mode++;
      if (o_set_valid) n_valid++;
      if (o_cmd_err)   n_err++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int hold = 1, input int gap = 3);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick();
      i_rx_data = 8'($urandom);
      repeat (hold - 1) tick();
      i_rx_done = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 1 + (i % 3), 2 + (i % 2));
   endtask

   initial begin
      int br, bc, bm, bv, be;
      reset = 1'b1;
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
      repeat (3) tick();
      check("reset_busy", o_busy, 0);
      check("reset_hour", o_set_hour, 0);
      reset = 1'b0;
      tick();

      br = n_run; be = n_err;
      send(8'h52, 200, 4);
      check("held_R_pulses", n_run - br, 1);
      check("held_R_err", n_err - be, 0);

      bv = n_valid;
      send_str("T123456");
      repeat (3) tick();
      check("set_count", n_valid - bv, 1);
      check("set_hour_12", o_set_hour, 12);
      check("set_min_34", o_set_min, 34);
      check("set_sec_56", o_set_sec, 56);

      bv = n_valid; be = n_err;
      send_str("T245900");
      send_str("T236000");
      repeat (3) tick();
      check("bad_time_err", n_err - be, 2);
      check("bad_time_valid", n_valid - bv, 0);
      check("held_hour", o_set_hour, 12);
      check("held_sec", o_set_sec, 56);

      be = n_err; bc = n_clr;
      send_str("T12");
      repeat (TMO + 10) tick();
      check("timeout_err", n_err - be, 1);
      check("timeout_busy", o_busy, 0);
      send(8'h63);
      check("clear_after_tmo", n_clr - bc, 1);

      be = n_err; bm = n_mode;
      send_str("T12M");
      check("cmd_in_collect_err", n_err - be, 1);
      check("cmd_in_collect_mode", n_mode - bm, 0);
      be = n_err;
      send_str("T1");
      send(8'h1B);
      check("esc_no_err", n_err - be, 0);
      check("esc_idle", o_busy, 0);

      send_str("T1234");
      reset = 1'b1;
      tick();
      check("midseq_reset_busy", o_busy, 0);
      check("midseq_reset_hour", o_set_hour, 0);
      check("midseq_reset_min", o_set_min, 0);
      tick();
      reset = 1'b0;
      tick();
      bv = n_valid;
      send_str("T000000");
      repeat (3) tick();
      check("zero_set_count", n_valid - bv, 1);
      check("zero_set_hour", o_set_hour, 0);
      be = n_err; br = n_run; bc = n_clr; bm = n_mode;
      send(8'h78);
      check("x_err", n_err - be, 1);
      be = n_err;
      send(8'h0D);
      send(8'h0A);
      check("crlf_no_err", n_err - be, 0);
      check("crlf_no_pulse", (n_run - br) + (n_clr - bc) + (n_mode - bm), 0);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int k = 0; k < 300; k++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 2) begin
            send($urandom_range(0, 1) ? 8'h54 : 8'h74, $urandom_range(1, 4), $urandom_range(1, 4));
            send(8'(8'h30 + $urandom_range(0, 2)), $urandom_range(1, 4), $urandom_range(1, 4));
            for (int d = 1; d < 6; d++) begin
               int lim;
               lim = (d == 2 || d == 4) ? 6 : 9;
               send(8'(8'h30 + $urandom_range(0, lim)), $urandom_range(1, 4), $urandom_range(1, 4));
            end
         end else if (sel == 3) begin
            send(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
         end else if (sel <= 5) begin
            case ($urandom_range(0, 5))
               0: send(8'h52); 1: send(8'h72); 2: send(8'h43);
               3: send(8'h63); 4: send(8'h4D); default: send(8'h6D);
            endcase
         end else if (sel == 6) begin
            case ($urandom_range(0, 3))
               0: send(8'h1B); 1: send(8'h0D); 2: send(8'h0A); default: send(8'h20);
            endcase
         end else if (sel == 7) begin
            send(8'h54);
            send(8'h31);
            repeat ($urandom_range(TMO - 2, TMO + 3)) tick();
         end else begin
            send(8'(8'h30 + $urandom_range(0, 9)), $urandom_range(1, 3), $urandom_range(1, 3));
         end
      end
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
